// File: rtl/pc_fetch_ctrl.sv
// PC register and req/ack instruction-fetch sequencer for the Neander PC path.
// Optional macro FETCH_TIMEOUT_EN adds a REQ timeout with a fetch_err pulse.
module pc_fetch_ctrl #(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] RESET_PC       = '0,
    parameter int               TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             pc_load,
    input  logic             fetch_start,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] instr,
    output logic             fetch_done,
    output logic             busy,
    output logic             fetch_err
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0] state;
    logic       timeout_hit;

    assign pc_inc     = pc + WIDTH'(1);
    assign mem_req    = (state == REQ);
    assign mem_addr   = mem_req ? pc : '0;
    assign fetch_done = (state == DONE);
    assign busy       = (state != IDLE);

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Counts REQ cycles already spent without an ack; expiry is the last allowed cycle.
    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = (state == REQ) && !mem_ack && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= timeout_hit;
            if (state == IDLE && fetch_start)
                tmo_cnt <= '0;
            else if (state == REQ && !mem_ack)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign fetch_err      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A same-cycle load feeds the fetch that starts now.
                    if (pc_load)
                        pc <= pc_next;
                    if (fetch_start)
                        state <= REQ;
                end
                REQ: begin
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        pc    <= pc_inc;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl against a transaction-level reference model.
// Define FETCH_TIMEOUT_EN for both files to exercise the timeout build.
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc_next;
    logic       pc_load;
    logic       fetch_start;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] pc;
    logic [7:0] pc_inc;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] instr;
    logic       fetch_done;
    logic       busy;
    logic       fetch_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a fetch is either outstanding, just completed, or absent.
    int  m_pc, m_instr, m_waited;
    bit  m_outstanding, m_completed, m_err;

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_next    (pc_next),
        .pc_load    (pc_load),
        .fetch_start(fetch_start),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .pc_inc     (pc_inc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .instr      (instr),
        .fetch_done (fetch_done),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_pc = 0; m_instr = 0; m_outstanding = 0; m_completed = 0; m_err = 0; m_waited = 0;
            return;
        end
        m_err = 0;
        if (m_completed) begin
            m_completed = 0;
        end else if (m_outstanding) begin
            if (mem_ack) begin
                m_instr       = mem_rdata;
                m_pc          = (m_pc + 1) % 256;
                m_outstanding = 0;
                m_completed   = 1;
            end else begin
                m_waited++;
`ifdef FETCH_TIMEOUT_EN
                if (m_waited == 15) begin
                    m_outstanding = 0;
                    m_err         = 1;
                end
`endif
            end
        end else begin
            if (pc_load) m_pc = pc_next;
            if (fetch_start) begin
                m_outstanding = 1;
                m_waited      = 0;
            end
        end
    endtask

    task automatic check_all();
        check("pc",         pc,         m_pc);
        check("pc_inc",     pc_inc,     (m_pc + 1) % 256);
        check("mem_req",    mem_req,    m_outstanding);
        check("mem_addr",   mem_addr,   m_outstanding ? m_pc : 0);
        check("instr",      instr,      m_instr);
        check("fetch_done", fetch_done, m_completed);
        check("busy",       busy,       m_outstanding | m_completed);
        check("fetch_err",  fetch_err,  m_err);
    endtask

    // Apply one cycle of inputs, let the edge happen, then compare at the falling edge.
    task automatic cycle(input bit r, input logic [7:0] pn, input bit ld, input bit fs,
                         input bit ack, input logic [7:0] rd);
        rst_n = r; pc_next = pn; pc_load = ld; fetch_start = fs; mem_ack = ack; mem_rdata = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Reset held two cycles with fetch_start asserted
        cycle(0, 8'h00, 0, 1, 0, 8'h00);
        cycle(0, 8'h00, 0, 1, 0, 8'h00);
        check("rst_pc", pc, 8'h00);
        check("rst_busy", busy, 1'b0);

        // Zero-wait fetch at pc=10
        cycle(1, 8'h10, 1, 0, 0, 8'h00);
        cycle(1, 8'h00, 0, 1, 0, 8'h00);
        check("zw_addr", mem_addr, 8'h10);
        cycle(1, 8'h00, 0, 0, 1, 8'hA5);
        check("zw_done", fetch_done, 1'b1);
        check("zw_instr", instr, 8'hA5);
        check("zw_pc", pc, 8'h11);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);
        check("zw_done_pulse", fetch_done, 1'b0);

        // Load and fetch in the same cycle
        cycle(1, 8'h05, 1, 0, 0, 8'h00);
        cycle(1, 8'h3C, 1, 1, 0, 8'h00);
        check("coll_addr", mem_addr, 8'h3C);
        cycle(1, 8'h00, 0, 0, 1, 8'h12);
        check("coll_pc", pc, 8'h3D);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);

        // Wrap from FF, loads ignored while waiting
        cycle(1, 8'hFF, 1, 0, 0, 8'h00);
        cycle(1, 8'h00, 0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1, 8'h77, 1, 1, 0, 8'h00);
        check("wrap_addr", mem_addr, 8'hFF);
        cycle(1, 8'h77, 1, 0, 1, 8'h9C);
        check("wrap_pc", pc, 8'h00);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);

        // Reset during the second REQ cycle, late ack ignored
        cycle(1, 8'h40, 1, 0, 0, 8'h00);
        cycle(1, 8'h00, 0, 1, 0, 8'h00);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);
        cycle(0, 8'h00, 0, 0, 0, 8'h00);
        cycle(1, 8'h00, 0, 0, 1, 8'h5A);
        check("rmid_pc", pc, 8'h00);
        check("rmid_instr", instr, 8'h00);
        check("rmid_done", fetch_done, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        // No ack for 15 REQ cycles
        cycle(1, 8'h20, 1, 1, 0, 8'h00);
        for (int i = 0; i < 15; i++) cycle(1, 8'h00, 0, 0, 0, 8'h00);
        check("tmo_err", fetch_err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        check("tmo_pc", pc, 8'h20);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);
        check("tmo_err_pulse", fetch_err, 1'b0);
        // Ack in the 15th REQ cycle
        cycle(1, 8'h00, 0, 1, 0, 8'h00);
        for (int i = 0; i < 14; i++) cycle(1, 8'h00, 0, 0, 0, 8'h00);
        cycle(1, 8'h00, 0, 0, 1, 8'hE7);
        check("tmo_late_done", fetch_done, 1'b1);
        check("tmo_late_err", fetch_err, 1'b0);
        check("tmo_late_pc", pc, 8'h21);
        cycle(1, 8'h00, 0, 0, 0, 8'h00);
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 49) != 0, 8'($urandom), ($urandom % 4) == 0,
                  ($urandom % 3) == 0, ($urandom % 3) == 0, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and instruction-fetch sequencer for the Neander PC path. It sits directly downstream of the 8-bit 2:1 PC-select mux. It consumes the mux output as pc_next, holds the architectural PC, and produces pc_inc (PC+1), which feeds the mux's em0 leg. It also runs a req/ack fetch handshake to memory and latches the fetched byte for the control unit.

Parameters:
WIDTH, 8, PC / address / data width in bits
RESET_PC, 8'h00, PC value after reset
TIMEOUT_CYCLES, 15, max cycles in REQ before abort (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
pc_next  input  WIDTH  next-PC value from the PC-select mux output
pc_load  input  1  load pc_next into PC (accepted in IDLE only)
fetch_start  input  1  request an instruction fetch at current PC (accepted in IDLE only)
mem_ack  input  1  memory has returned mem_rdata this cycle
mem_rdata  input  WIDTH  fetched byte, valid when mem_ack=1
pc  output  WIDTH  current program counter
pc_inc  output  WIDTH  pc+1 modulo 2^WIDTH, combinational; feeds mux em0
mem_req  output  1  fetch request to memory
mem_addr  output  WIDTH  fetch address, equals pc while mem_req=1, else 0
instr  output  WIDTH  last fetched byte
fetch_done  output  1  one-cycle pulse when instr is updated
busy  output  1  high whenever FSM is not in IDLE
fetch_err  output  1  one-cycle timeout pulse (only with FETCH_TIMEOUT_EN, else tied 0)

Behaviour:
- Reset (rst_n=0 at clk edge): pc=RESET_PC, instr=0, FSM=IDLE, mem_req=0, fetch_done=0, fetch_err=0, timeout counter=0. Reset wins over every other input, including mid-fetch: any outstanding request is dropped and a later mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - pc_load=1 -> pc<=pc_next.
  - fetch_start=1 -> REQ.
  - Both asserted in the same cycle: pc<=pc_next and go to REQ. The fetch then uses the newly loaded PC.
- REQ:
  - mem_req=1 and mem_addr=pc, held stable until ack.
  - On mem_ack=1: instr<=mem_rdata, pc<=pc_inc, go to DONE.
  - pc_load and fetch_start are ignored.
  - mem_ack outside REQ is ignored.
- DONE:
  - fetch_done=1 for exactly this one cycle, mem_req=0, then unconditionally return to IDLE.
  - pc_load and fetch_start are ignored in this cycle.
- Latency: a zero-wait memory (mem_ack in the first REQ cycle) gives fetch_start at edge N, mem_req high in cycle N+1, fetch_done in cycle N+2, next fetch accepted in cycle N+3.
- PC arithmetic: pc_inc = pc+1, truncated to WIDTH. 8'hFF wraps to 8'h00 with no flag.
- busy = (state != IDLE). All outputs except pc_inc are registered or decoded from registered state only.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When TIMEOUT_CYCLES cycles pass without ack, the FSM goes to IDLE. It pulses fetch_err for 1 cycle and leaves pc and instr unchanged; no fetch_done is issued.
  - mem_ack arriving in the same cycle as the expiry takes priority, and the fetch completes normally.
- Undefined: no counter exists, REQ waits indefinitely, and fetch_err is constant 0.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with fetch_start=1 -> pc=00, mem_req=0, busy=0, instr=00.
- Zero-wait fetch: pc=10, fetch_start pulse, mem_ack+rdata=A5 in the first REQ cycle -> mem_addr=10 during REQ, then instr=A5, pc=11, and a single fetch_done pulse 2 cycles after start.
- Load+fetch collision: in IDLE with pc=05, assert pc_load (pc_next=3C) and fetch_start together -> mem_addr=3C, and pc=3D after ack.
- Wrap and ignore: pc=FF, fetch with 3 wait cycles while pc_load=1 (pc_next=77) during REQ -> load ignored, pc=00 after ack.
- Reset mid-fetch: rst_n=0 in the 2nd REQ cycle, then mem_ack=1 the next cycle -> pc=00, instr unchanged from reset value 00, no fetch_done.
- FETCH_TIMEOUT_EN: no ack for 15 cycles -> fetch_err pulses once, busy drops, pc is unchanged. A repeat run with ack in cycle 15 completes the fetch normally with no fetch_err.
